// File: rtl/coax_tx_pkg.sv
// Purpose: shared types for the 3270 coax transmitter (frame states, word width, Manchester helper).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package coax_tx_pkg;

  localparam int WORD_W        = 10;
  localparam int QUIESCE_CELLS = 5;

  // Frame sequencing states, in transmission order.
  typedef enum logic [3:0] {
    IDLE              = 4'd0,
    LINE_QUIESCE      = 4'd1,
    CODE_VIOLATION_LO = 4'd2,
    CODE_VIOLATION_HI = 4'd3,
    SYNC_BIT          = 4'd4,
    DATA_BIT          = 4'd5,
    PARITY_BIT        = 4'd6,
    END_SEQUENCE_1    = 4'd7,
    END_SEQUENCE_2    = 4'd8
  } state_t;

  // Line level for bit b: inverted in the first half-cell, true in the second.
  function automatic logic manchester(input logic b, input logic first_half);
    return first_half ? ~b : b;
  endfunction

endpackage

// File: rtl/coax_tx_if.sv
// Purpose: word handshake and line-driver pins of the coax transmitter.
// Latency: n/a (wiring only).
// Backpressure: ready low means the one-word holding register is occupied.
interface coax_tx_if;
  import coax_tx_pkg::*;

  logic [WORD_W-1:0] data;
  logic              strobe;
  logic              ready;
  logic              tx;
  logic              active;

  modport master (output data, output strobe, input ready, input tx, input active);
  modport slave  (input data, input strobe, output ready, output tx, output active);

endinterface

// File: rtl/coax_tx_bit_timer.sv
// Purpose: free-running bit-cell timer counting 0..CLOCKS_PER_BIT-1, with half-cell markers.
// Latency: markers are combinational from the count register.
// Backpressure: none; restart holds the count at zero.
module coax_tx_bit_timer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic first_half,
  output logic mid_clock,
  output logic last_clock
);

  localparam int HALF = CLOCKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLOCKS_PER_BIT);

  logic [CW-1:0] cnt;

  // Cell position counter; wraps at the end of every bit cell.
  always_ff @(posedge clk) begin
    if (reset || restart || last_clock) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign first_half = (cnt < CW'(HALF));
  assign mid_clock  = (cnt == CW'(HALF - 1));
  assign last_clock = (cnt == CW'(CLOCKS_PER_BIT - 1));

endmodule

// File: rtl/coax_tx.sv
// Purpose: 3270 coax frame transmitter: quiesce, code violation, per-word sync/data/parity, end sequence.
// Latency: tx/active change on the clock after a word is accepted in IDLE; all outputs registered.
// Backpressure: ready = holding register empty; strobe while ready is low is ignored.
module coax_tx
  import coax_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8
) (
  input logic     clk,
  input logic     reset,
  coax_tx_if.slave bus
);

  state_t              state_q, state_d;
  logic [2:0]          cell_q, cell_d;
  logic [3:0]          bit_q, bit_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                parity_q, parity_d;
  logic                tx_q, tx_d;
  logic                active_q;
  logic                load;
  logic                accept;
  logic                first_half, mid_clock, last_clock;
  logic                half_end, fh_nxt;

  coax_tx_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .restart    (state_q == IDLE),
    .first_half (first_half),
    .mid_clock  (mid_clock),
    .last_clock (last_clock)
  );

  assign accept   = bus.strobe && !hold_vld_q;
  assign half_end = mid_clock || last_clock;
  // Half-cell phase the timer will show next cycle, so tx can be registered.
  assign fh_nxt   = (state_q == IDLE) || last_clock || (first_half && !mid_clock);

  // Next-state, counters, shift/holding registers and next line level.
  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    load       = 1'b0;
    tx_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_vld_q || accept) begin
          state_d = LINE_QUIESCE;
          cell_d  = '0;
        end
      end
      LINE_QUIESCE: begin
        if (last_clock) begin
          if (cell_q == 3'(QUIESCE_CELLS - 1)) begin
            state_d = CODE_VIOLATION_LO;
            cell_d  = '0;
          end else begin
            cell_d = cell_q + 3'd1;
          end
        end
      end
      // The 1.5-cell violation halves are counted in half-cells.
      CODE_VIOLATION_LO: begin
        if (half_end) begin
          if (cell_q == 3'd2) begin
            state_d = CODE_VIOLATION_HI;
            cell_d  = '0;
          end else begin
            cell_d = cell_q + 3'd1;
          end
        end
      end
      CODE_VIOLATION_HI: begin
        if (half_end) begin
          if (cell_q == 3'd2) begin
            state_d = SYNC_BIT;
            load    = 1'b1;
          end else begin
            cell_d = cell_q + 3'd1;
          end
        end
      end
      SYNC_BIT: begin
        if (last_clock) begin
          state_d = DATA_BIT;
          bit_d   = '0;
        end
      end
      DATA_BIT: begin
        if (last_clock) begin
          shift_d = {shift_q[WORD_W-2:0], 1'b0};
          if (bit_q == 4'(WORD_W - 1)) begin
            state_d = PARITY_BIT;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      // A held word continues the frame with no gap.
      PARITY_BIT: begin
        if (last_clock) begin
          if (hold_vld_q) begin
            state_d = SYNC_BIT;
            load    = 1'b1;
          end else begin
            state_d = END_SEQUENCE_1;
          end
        end
      end
      END_SEQUENCE_1: begin
        if (last_clock) begin
          state_d = END_SEQUENCE_2;
          cell_d  = '0;
        end
      end
      END_SEQUENCE_2: begin
        if (last_clock) begin
          if (cell_q == 3'd1) begin
            state_d = IDLE;
          end else begin
            cell_d = cell_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d    = hold_q;
      parity_d   = ^hold_q;
      hold_vld_d = 1'b0;
    end
    if (accept) begin
      hold_d     = bus.data;
      hold_vld_d = 1'b1;
    end

    case (state_d)
      LINE_QUIESCE, SYNC_BIT: tx_d = manchester(1'b1, fh_nxt);
      CODE_VIOLATION_HI:      tx_d = 1'b1;
      DATA_BIT:               tx_d = manchester(shift_d[WORD_W-1], fh_nxt);
      PARITY_BIT:             tx_d = manchester(parity_d, fh_nxt);
      END_SEQUENCE_1:         tx_d = manchester(1'b0, fh_nxt);
      END_SEQUENCE_2:         tx_d = 1'b1;
      default:                tx_d = 1'b0;
    endcase
  end

  // State and datapath registers; reset aborts any frame and drops the held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cell_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cell_q     <= cell_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      active_q   <= (state_d != IDLE);
    end
  end

  assign bus.ready  = !hold_vld_q;
  assign bus.tx     = tx_q;
  assign bus.active = active_q;

endmodule
